branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Upstream producer and downstream consumer of the ID/EX branch-prediction fields.
- In ID, it predicts branches with a 2-bit saturating counter and drives the prediction bit into the ID/EX stage.
- In EX, it resolves the branch the ID/EX stage carried forward and drives the IF/ID and ID/EX flush controls and the PC redirect.
- It also keeps branch and mispredict statistics.

Parameters:
- INIT_STATE, 2'b11, counter value loaded on reset (00 SNT, 01 WNT, 10 WT, 11 ST).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- ID_Branch_i  in  1  a branch is decoded in ID this cycle.
- ID_Branch_PC_i  in  32  branch target computed in ID.
- Stall_i  in  1  load-use stall; ID/IF are held this cycle.
- EX_Branch_i  in  1  the instruction in EX is a branch.
- EX_BranchPredict_i  in  1  prediction that travelled with the EX branch.
- EX_Zero_i  in  1  actual outcome, 1 = taken (rs1 == rs2).
- EX_PC_i  in  32  PC of the EX branch.
- EX_Branch_PC_i  in  32  target of the EX branch.
- BranchPredict_o  out  1  prediction for the ID branch, to the ID/EX stage.
- Redirect_o  out  1  PC mux selects Redirect_PC_o.
- Redirect_PC_o  out  32  next fetch PC when Redirect_o = 1.
- IFID_flush_o  out  1  kill the IF/ID contents at the next posedge.
- IDEX_flush_o  out  1  kill the ID/EX contents at the next posedge.
- Mispredict_o  out  1  EX branch was mispredicted.
- Predict_state_o  out  2  current counter state.
- Branch_count_o  out  CNT_W  number of resolved EX branches.
- Mispredict_count_o  out  CNT_W  number of mispredictions.

Behaviour:
- Reset (rst_i = 0, asynchronous, takes effect immediately, including between clock edges):
  - counter state = INIT_STATE;
  - both statistics counters = 0.
  - All other outputs are combinational and are 0 whenever the ID_Branch_i and EX_Branch_i inputs are 0.
- Prediction (combinational, always uses the pre-update state):
  - BranchPredict_o = ID_Branch_i & state[1].
- Mispredict (combinational):
  - Mispredict_o = EX_Branch_i & (EX_Zero_i != EX_BranchPredict_i).
  - Recovery PC = EX_Zero_i ? EX_Branch_PC_i : EX_PC_i + 4, taken modulo 2^32.
- Redirect priority:
  1. Mispredict_o = 1: Redirect_o = 1, Redirect_PC_o = recovery PC, IFID_flush_o = 1, IDEX_flush_o = 1. Stall_i is ignored.
  2. Otherwise, BranchPredict_o = 1 and Stall_i = 0: Redirect_o = 1, Redirect_PC_o = ID_Branch_PC_i, IFID_flush_o = 1, IDEX_flush_o = 0.
  3. Otherwise: Redirect_o = 0, Redirect_PC_o = 0, both flushes 0.
- Stalled ID branch:
  - BranchPredict_o is still driven, but no redirect and no flush are issued.
  - The prediction is re-evaluated on the cycle the stall releases.
- Counter update, on posedge when EX_Branch_i = 1:
  - EX_Zero_i = 1: state increments, saturating at 11.
  - EX_Zero_i = 0: state decrements, saturating at 00.
  - The update happens in the same cycle as resolution; the ID prediction in that cycle sees the old state.
- Statistics, on posedge:
  - Branch_count increments when EX_Branch_i = 1.
  - Mispredict_count increments when Mispredict_o = 1.
  - Both saturate at all-ones; no wrap.
- Latency:
  - Prediction, flushes and redirect are 0-cycle combinational; the pipeline stages and the PC register capture them at the next posedge.
  - State and counters become visible 1 cycle after the resolving edge.

Decomposition:
- Shared package (bp_pkg):
  - state encodings SNT/WNT/WT/ST;
  - PC_INC = 32'd4.
- One sub-module, bp_sat_counter:
  - 2-bit up/down saturating counter;
  - inputs: clk, async active-low reset, enable, taken;
  - parameterised reset value.
- All redirect and flush logic stays in the top module.

Test Plan:
- Reset with INIT_STATE = 11, rst_i released:
  - Predict_state_o = 11, both counts 0.
  - ID_Branch_i = 1, ID_Branch_PC_i = 0x100 -> BranchPredict_o = 1, Redirect_o = 1, Redirect_PC_o = 0x100, IFID_flush_o = 1, IDEX_flush_o = 0.
- Mispredict:
  - State 11, EX_Branch_i = 1, EX_BranchPredict_i = 1, EX_Zero_i = 0, EX_PC_i = 0x40.
  - Same cycle -> Mispredict_o = 1, Redirect_PC_o = 0x44, both flushes 1.
  - Next cycle -> state 10, Mispredict_count_o = 1, Branch_count_o = 1.
- Saturation:
  - Four not-taken resolutions from 11 -> states 10, 01, 00, 00.
  - Then ID_Branch_i = 1 -> BranchPredict_o = 0, Redirect_o = 0.
  - Four taken resolutions -> states 01, 10, 11, 11.
- Simultaneous events:
  - State 10; EX not-taken mispredict at EX_PC_i = 0xFFFFFFFC, and ID branch with target 0x200 in the same cycle.
  - Required -> Redirect_PC_o = 0x00000000 (wrap), both flushes 1, BranchPredict_o = 1 (old state).
  - Next state 01.
- Stall:
  - State 11, ID_Branch_i = 1, Stall_i = 1 -> BranchPredict_o = 1, Redirect_o = 0, IFID_flush_o = 0.
  - Stall_i drops -> Redirect_o = 1.
- Asynchronous reset mid-operation:
  - State 01, Branch_count_o = 5.
  - Drop rst_i between edges -> state = INIT_STATE and counts = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encodings and the redirect bundle.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic        redirect;
    logic [31:0] pc;
    logic        ifid_flush;
    logic        idex_flush;
  } bp_redir_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit up/down saturating predictor counter.
// Steps toward taken or not-taken when enabled.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter logic [1:0] RST_VAL = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (taken_i) begin
      if (state_q != ST)
        state_d = state_q + 2'd1;
    end else begin
      if (state_q != SNT)
        state_d = state_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state_q <= RST_VAL;
    else if (en_i)
      state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/branch_predict_unit.sv
// ID-stage predictor and EX-stage resolver.
// Drives flushes, PC redirect and statistics.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = 2'b11,
  parameter int         CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_Branch_i,
  input  logic [31:0]      ID_Branch_PC_i,
  input  logic             Stall_i,
  input  logic             EX_Branch_i,
  input  logic             EX_BranchPredict_i,
  input  logic             EX_Zero_i,
  input  logic [31:0]      EX_PC_i,
  input  logic [31:0]      EX_Branch_PC_i,
  output logic             BranchPredict_o,
  output logic             Redirect_o,
  output logic [31:0]      Redirect_PC_o,
  output logic             IFID_flush_o,
  output logic             IDEX_flush_o,
  output logic             Mispredict_o,
  output logic [1:0]       Predict_state_o,
  output logic [CNT_W-1:0] Branch_count_o,
  output logic [CNT_W-1:0] Mispredict_count_o
);

  logic [1:0]       state;
  logic             mispredict;
  logic             id_take;
  logic [31:0]      recover_pc;
  bp_redir_t        redir;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;

  bp_sat_counter #(
    .RST_VAL(INIT_STATE)
  ) u_sat_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (EX_Branch_i),
    .taken_i(EX_Zero_i),
    .state_o(state)
  );

  assign BranchPredict_o = ID_Branch_i & state[1];

  assign mispredict =
    EX_Branch_i & (EX_Zero_i ^ EX_BranchPredict_i);

  assign recover_pc = EX_Zero_i ? EX_Branch_PC_i
                                : EX_PC_i + PC_INC;

  // A stalled ID branch must not redirect; EX recovery wins anyway.
  assign id_take =
    ~mispredict & BranchPredict_o & ~Stall_i;

  always_comb begin
    redir = '0;
    unique case (1'b1)
      mispredict: begin
        redir.redirect   = 1'b1;
        redir.pc         = recover_pc;
        redir.ifid_flush = 1'b1;
        redir.idex_flush = 1'b1;
      end
      id_take: begin
        redir.redirect   = 1'b1;
        redir.pc         = ID_Branch_PC_i;
        redir.ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign Redirect_o    = redir.redirect;
  assign Redirect_PC_o = redir.pc;
  assign IFID_flush_o  = redir.ifid_flush;
  assign IDEX_flush_o  = redir.idex_flush;
  assign Mispredict_o  = mispredict;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (EX_Branch_i && br_cnt_q != '1)
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (mispredict && mp_cnt_q != '1)
        mp_cnt_q <= mp_cnt_q + CNT_W'(1);
    end
  end

  assign Predict_state_o    = state;
  assign Branch_count_o     = br_cnt_q;
  assign Mispredict_count_o = mp_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit.
// Inputs change after negedge; outputs sampled between edges.
module tb_branch_predict_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ID_Branch_i;
  logic [31:0] ID_Branch_PC_i;
  logic        Stall_i;
  logic        EX_Branch_i;
  logic        EX_BranchPredict_i;
  logic        EX_Zero_i;
  logic [31:0] EX_PC_i;
  logic [31:0] EX_Branch_PC_i;
  logic        BranchPredict_o;
  logic        Redirect_o;
  logic [31:0] Redirect_PC_o;
  logic        IFID_flush_o;
  logic        IDEX_flush_o;
  logic        Mispredict_o;
  logic [1:0]  Predict_state_o;
  logic [15:0] Branch_count_o;
  logic [15:0] Mispredict_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  branch_predict_unit #(
    .INIT_STATE(2'b11),
    .CNT_W     (16)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ID_Branch_i       (ID_Branch_i),
    .ID_Branch_PC_i    (ID_Branch_PC_i),
    .Stall_i           (Stall_i),
    .EX_Branch_i       (EX_Branch_i),
    .EX_BranchPredict_i(EX_BranchPredict_i),
    .EX_Zero_i         (EX_Zero_i),
    .EX_PC_i           (EX_PC_i),
    .EX_Branch_PC_i    (EX_Branch_PC_i),
    .BranchPredict_o   (BranchPredict_o),
    .Redirect_o        (Redirect_o),
    .Redirect_PC_o     (Redirect_PC_o),
    .IFID_flush_o      (IFID_flush_o),
    .IDEX_flush_o      (IDEX_flush_o),
    .Mispredict_o      (Mispredict_o),
    .Predict_state_o   (Predict_state_o),
    .Branch_count_o    (Branch_count_o),
    .Mispredict_count_o(Mispredict_count_o)
  );

  task automatic idle();
    ID_Branch_i        = 1'b0;
    ID_Branch_PC_i     = 32'h0;
    Stall_i            = 1'b0;
    EX_Branch_i        = 1'b0;
    EX_BranchPredict_i = 1'b0;
    EX_Zero_i          = 1'b0;
    EX_PC_i            = 32'h0;
    EX_Branch_PC_i     = 32'h0;
  endtask

  // Resolve one EX branch on the next posedge, leave inputs idle.
  task automatic resolve(input logic taken, input logic pred);
    @(negedge clk_i);
    EX_Branch_i        = 1'b1;
    EX_Zero_i          = taken;
    EX_BranchPredict_i = pred;
    EX_PC_i            = 32'h1000;
    EX_Branch_PC_i     = 32'h2000;
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (Predict_state_o !== 2'b11) begin
      errors++;
      $display("FAIL reset_state got %b exp 11", Predict_state_o);
    end
    checks++;
    if (Branch_count_o !== 16'd0 || Mispredict_count_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got %0d/%0d exp 0/0",
               Branch_count_o, Mispredict_count_o);
    end
    checks++;
    if ({BranchPredict_o, Redirect_o, IFID_flush_o, IDEX_flush_o,
         Mispredict_o} !== 5'b0 || Redirect_PC_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle_outs got %b pc %h exp 0",
               {BranchPredict_o, Redirect_o, IFID_flush_o,
                IDEX_flush_o, Mispredict_o}, Redirect_PC_o);
    end
    ID_Branch_i    = 1'b1;
    ID_Branch_PC_i = 32'h100;
    #1;
    checks++;
    if ({BranchPredict_o, Redirect_o, IFID_flush_o, IDEX_flush_o}
        !== 4'b1110 || Redirect_PC_o !== 32'h100) begin
      errors++;
      $display("FAIL id_predict got %b pc %h exp 1110 pc 00000100",
               {BranchPredict_o, Redirect_o, IFID_flush_o,
                IDEX_flush_o}, Redirect_PC_o);
    end
    idle();
  endtask

  task automatic test_mispredict();
    @(negedge clk_i);
    EX_Branch_i        = 1'b1;
    EX_BranchPredict_i = 1'b1;
    EX_Zero_i          = 1'b0;
    EX_PC_i            = 32'h40;
    EX_Branch_PC_i     = 32'h80;
    #1;
    checks++;
    if ({Mispredict_o, Redirect_o, IFID_flush_o, IDEX_flush_o}
        !== 4'b1111 || Redirect_PC_o !== 32'h44) begin
      errors++;
      $display("FAIL mispredict_nt got %b pc %h exp 1111 pc 00000044",
               {Mispredict_o, Redirect_o, IFID_flush_o,
                IDEX_flush_o}, Redirect_PC_o);
    end
    @(posedge clk_i);
    #1;
    idle();
    checks++;
    if (Predict_state_o !== 2'b10 || Mispredict_count_o !== 16'd1 ||
        Branch_count_o !== 16'd1) begin
      errors++;
      $display("FAIL mispredict_update got st %b bc %0d mc %0d exp 10 1 1",
               Predict_state_o, Branch_count_o, Mispredict_count_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] dn_exp [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] up_exp [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0, 1'b0);
      checks++;
      if (Predict_state_o !== dn_exp[i]) begin
        errors++;
        $display("FAIL sat_down[%0d] got %b exp %b",
                 i, Predict_state_o, dn_exp[i]);
      end
    end
    @(negedge clk_i);
    ID_Branch_i    = 1'b1;
    ID_Branch_PC_i = 32'h300;
    #1;
    checks++;
    if (BranchPredict_o !== 1'b0 || Redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL snt_predict got bp %b rd %b exp 0 0",
               BranchPredict_o, Redirect_o);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      resolve(1'b1, 1'b1);
      checks++;
      if (Predict_state_o !== up_exp[i]) begin
        errors++;
        $display("FAIL sat_up[%0d] got %b exp %b",
                 i, Predict_state_o, up_exp[i]);
      end
    end
    checks++;
    if (Branch_count_o !== 16'd8 || Mispredict_count_o !== 16'd0) begin
      errors++;
      $display("FAIL sat_counts got %0d/%0d exp 8/0",
               Branch_count_o, Mispredict_count_o);
    end
  endtask

  task automatic test_simultaneous();
    resolve(1'b0, 1'b1);
    @(negedge clk_i);
    EX_Branch_i        = 1'b1;
    EX_BranchPredict_i = 1'b1;
    EX_Zero_i          = 1'b0;
    EX_PC_i            = 32'hFFFF_FFFC;
    EX_Branch_PC_i     = 32'h10;
    ID_Branch_i        = 1'b1;
    ID_Branch_PC_i     = 32'h200;
    #1;
    checks++;
    if (Redirect_PC_o !== 32'h0 || {IFID_flush_o, IDEX_flush_o}
        !== 2'b11 || BranchPredict_o !== 1'b1 || Redirect_o !== 1'b1) begin
      errors++;
      $display("FAIL simul got pc %h fl %b bp %b rd %b exp 0 11 1 1",
               Redirect_PC_o, {IFID_flush_o, IDEX_flush_o},
               BranchPredict_o, Redirect_o);
    end
    @(posedge clk_i);
    #1;
    idle();
    checks++;
    if (Predict_state_o !== 2'b01) begin
      errors++;
      $display("FAIL simul_state got %b exp 01", Predict_state_o);
    end
  endtask

  task automatic test_taken_paths();
    @(negedge clk_i);
    EX_Branch_i        = 1'b1;
    EX_BranchPredict_i = 1'b0;
    EX_Zero_i          = 1'b1;
    EX_PC_i            = 32'h500;
    EX_Branch_PC_i     = 32'h300;
    #1;
    checks++;
    if (Mispredict_o !== 1'b1 || Redirect_PC_o !== 32'h300 ||
        IDEX_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL taken_mispredict got mp %b pc %h fl %b exp 1 300 1",
               Mispredict_o, Redirect_PC_o, IDEX_flush_o);
    end
    @(negedge clk_i);
    EX_BranchPredict_i = 1'b1;
    #1;
    checks++;
    if ({Mispredict_o, Redirect_o, IFID_flush_o, IDEX_flush_o}
        !== 4'b0 || Redirect_PC_o !== 32'h0) begin
      errors++;
      $display("FAIL correct_pred got %b pc %h exp 0000 pc 0",
               {Mispredict_o, Redirect_o, IFID_flush_o,
                IDEX_flush_o}, Redirect_PC_o);
    end
    @(posedge clk_i);
    #1;
    idle();
    checks++;
    if (Predict_state_o !== 2'b11) begin
      errors++;
      $display("FAIL taken_state got %b exp 11", Predict_state_o);
    end
  endtask

  task automatic test_stall();
    @(negedge clk_i);
    ID_Branch_i    = 1'b1;
    ID_Branch_PC_i = 32'h500;
    Stall_i        = 1'b1;
    #1;
    checks++;
    if ({BranchPredict_o, Redirect_o, IFID_flush_o, IDEX_flush_o}
        !== 4'b1000) begin
      errors++;
      $display("FAIL stall_hold got %b exp 1000",
               {BranchPredict_o, Redirect_o, IFID_flush_o,
                IDEX_flush_o});
    end
    @(negedge clk_i);
    Stall_i = 1'b0;
    #1;
    checks++;
    if ({Redirect_o, IFID_flush_o, IDEX_flush_o} !== 3'b110 ||
        Redirect_PC_o !== 32'h500) begin
      errors++;
      $display("FAIL stall_release got %b pc %h exp 110 pc 500",
               {Redirect_o, IFID_flush_o, IDEX_flush_o}, Redirect_PC_o);
    end
    idle();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    resolve(1'b0, 1'b0);
    resolve(1'b0, 1'b0);
    resolve(1'b0, 1'b0);
    resolve(1'b0, 1'b0);
    resolve(1'b1, 1'b0);
    checks++;
    if (Predict_state_o !== 2'b01 || Branch_count_o !== 16'd5 ||
        Mispredict_count_o !== 16'd1) begin
      errors++;
      $display("FAIL pre_async got st %b bc %0d mc %0d exp 01 5 1",
               Predict_state_o, Branch_count_o, Mispredict_count_o);
    end
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (Predict_state_o !== 2'b11 || Branch_count_o !== 16'd0 ||
        Mispredict_count_o !== 16'd0) begin
      errors++;
      $display("FAIL async_reset got st %b bc %0d mc %0d exp 11 0 0",
               Predict_state_o, Branch_count_o, Mispredict_count_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_saturation();
    test_simultaneous();
    test_taken_paths();
    test_stall();
    test_async_reset();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
